// File: rtl/tqvp_rng_fifo_if.sv
// rtl/tqvp_rng_fifo_if.sv - TinyQV register-bus bundle between the SPI front end and the RNG FIFO
//
// Signals:
//   address       6   register byte address
//   data_in       32  write data
//   data_write_n  2   write strobe: 11 none, 00 byte, 01 half, 10 word
//   data_read_n   2   read strobe: 11 none, anything else reads
//   data_out      32  read data (0 whenever data_ready is low)
//   data_ready    1   read data valid
// Modports: master = register front end, slave = peripheral.
interface tqvp_rng_fifo_if;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    modport master (
        output address, data_in, data_write_n, data_read_n,
        input  data_out, data_ready
    );

    modport slave (
        input  address, data_in, data_write_n, data_read_n,
        output data_out, data_ready
    );
endinterface

// File: rtl/tqvp_rng_fifo.sv
// rtl/tqvp_rng_fifo.sv - entropy sampler with von Neumann debiaser, 32-bit packer and word FIFO
//
// Ports:
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   ui_in[7:0]      synchronised inputs; ui_in[ENT_BIT] is the raw entropy bit
//   uo_out[7:0]     {irq, LEVEL[2:0], sample pulse, OVF, FULL, !EMPTY}
//   bus             register bus (slave side): CTRL 0x00, STATUS 0x04, DATA 0x08, DIV 0x0C
//   user_interrupt  registered FIFO threshold interrupt
module tqvp_rng_fifo #(
    parameter int DEPTH   = 4,
    parameter int ENT_BIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       ui_in,
    output logic [7:0]       uo_out,
    tqvp_rng_fifo_if.slave   bus,
    output logic             user_interrupt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_STATUS = 6'h04;
    localparam logic [5:0] A_DATA   = 6'h08;
    localparam logic [5:0] A_DIV    = 6'h0C;

    logic          en_q, en_d, debias_q, debias_d, irq_en_q, irq_en_d;
    logic [2:0]    thr_q, thr_d;
    logic [7:0]    div_q, div_d, div_cnt_q, div_cnt_d;
    logic          samp_q, samp_d;
    logic          pend_valid_q, pend_valid_d, pend_bit_q, pend_bit_d;
    logic [31:0]   word_q, word_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          push_q, push_d;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          rd_act_q, rd_act_d;
    logic [31:0]   rbuf_q, rbuf_d;
    logic          irq_q, irq_d;

    logic          wr_en, rd_strobe, rd_start, flush, sample, emit, emit_bit;
    logic          full, empty, do_pop, do_push;
    logic [8:0]    wmask, ctrl_new;
    logic [31:0]   ctrl_cur, rd_val;
    logic [3:0]    lvl4;
    logic          unused_bits;

    assign unused_bits = ^{bus.data_in[31:9], ui_in};

    assign lvl4     = 4'(level_q);
    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign ctrl_cur = {23'd0, irq_en_q, 1'b0, thr_q, 1'b0, 1'b0, debias_q, en_q};

    assign wr_en     = (bus.data_write_n != 2'b11);
    assign rd_strobe = (bus.data_read_n != 2'b11);
    // One capture per strobe: only the first strobe cycle after an idle one counts.
    assign rd_start  = rd_strobe & ~rd_act_q;
    assign sample    = en_q & (div_cnt_q == 8'd0);

    always_comb begin
        // Byte writes only reach [7:0], so IRQ_EN (bit 8) needs a half/word write.
        wmask    = (bus.data_write_n == 2'b00) ? 9'h0FF : 9'h1FF;
        ctrl_new = (ctrl_cur[8:0] & ~wmask) | (bus.data_in[8:0] & wmask);
        flush    = wr_en && (bus.address == A_CTRL) && ctrl_new[2];
        do_pop   = rd_start && (bus.address == A_DATA) && !empty;
        // Pop is applied first, so a push at full still fits when a pop coincides.
        do_push  = push_q && (!full || do_pop) && !flush;
    end

    // Register writes, divider, debiaser and collector.
    always_comb begin
        en_d         = en_q;
        debias_d     = debias_q;
        thr_d        = thr_q;
        irq_en_d     = irq_en_q;
        div_d        = div_q;
        div_cnt_d    = div_cnt_q;
        pend_valid_d = pend_valid_q;
        pend_bit_d   = pend_bit_q;
        word_d       = word_q;
        cnt_d        = cnt_q;
        push_d       = 1'b0;
        emit         = 1'b0;
        emit_bit     = 1'b0;
        samp_d       = sample;

        if (wr_en && bus.address == A_CTRL) begin
            en_d     = ctrl_new[0];
            debias_d = ctrl_new[1];
            thr_d    = ctrl_new[6:4];
            irq_en_d = ctrl_new[8];
        end
        if (wr_en && bus.address == A_DIV) begin
            div_d = bus.data_in[7:0];
        end

        if (!en_q) begin
            div_cnt_d = 8'd0;
        end else if (sample) begin
            div_cnt_d = div_q;
        end else begin
            div_cnt_d = div_cnt_q - 8'd1;
        end

        if (sample) begin
            if (debias_q) begin
                if (!pend_valid_q) begin
                    pend_valid_d = 1'b1;
                    pend_bit_d   = ui_in[ENT_BIT];
                end else begin
                    pend_valid_d = 1'b0;
                    // (0,1) -> 0, (1,0) -> 1: the first bit of an unequal pair.
                    emit     = (pend_bit_q != ui_in[ENT_BIT]);
                    emit_bit = pend_bit_q;
                end
            end else begin
                emit     = 1'b1;
                emit_bit = ui_in[ENT_BIT];
            end
        end

        if (emit) begin
            word_d = {word_q[30:0], emit_bit};
            cnt_d  = cnt_q + 5'd1;
            // Completed word stays in word_q for one cycle and is pushed at the next edge.
            push_d = (cnt_q == 5'd31);
        end

        if (!en_q || flush) begin
            pend_valid_d = 1'b0;
            word_d       = 32'd0;
            cnt_d        = 5'd0;
        end
        if (flush) begin
            push_d = 1'b0;
        end
    end

    // FIFO, overflow flag, read buffer and interrupt.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        rbuf_d   = rbuf_q;
        rd_act_d = rd_strobe;
        rd_val   = 32'd0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (do_push) begin
                mem_d[wr_ptr_q] = word_q;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                level_d = level_q + LW'(1);
            end else if (do_pop && !do_push) begin
                level_d = level_q - LW'(1);
            end
        end

        if (wr_en && bus.address == A_STATUS && bus.data_in[6]) begin
            ovf_d = 1'b0;
        end
        // A dropped word is never lost silently: setting beats a same-cycle clear.
        if (push_q && full && !do_pop && !flush) begin
            ovf_d = 1'b1;
        end

        case (bus.address)
            A_CTRL:   rd_val = ctrl_cur;
            A_STATUS: rd_val = {25'd0, ovf_q, empty, full, lvl4};
            A_DATA:   rd_val = empty ? 32'd0 : mem_q[rd_ptr_q];
            A_DIV:    rd_val = {24'd0, div_q};
            default:  rd_val = 32'd0;
        endcase
        if (rd_start) begin
            rbuf_d = rd_val;
        end

        irq_d = irq_en_q && (thr_q != 3'd0) && (lvl4 >= {1'b0, thr_q});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q         <= 1'b0;
            debias_q     <= 1'b0;
            thr_q        <= 3'd0;
            irq_en_q     <= 1'b0;
            div_q        <= 8'd0;
            div_cnt_q    <= 8'd0;
            samp_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_bit_q   <= 1'b0;
            word_q       <= 32'd0;
            cnt_q        <= 5'd0;
            push_q       <= 1'b0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            ovf_q        <= 1'b0;
            rd_act_q     <= 1'b0;
            rbuf_q       <= 32'd0;
            irq_q        <= 1'b0;
        end else begin
            en_q         <= en_d;
            debias_q     <= debias_d;
            thr_q        <= thr_d;
            irq_en_q     <= irq_en_d;
            div_q        <= div_d;
            div_cnt_q    <= div_cnt_d;
            samp_q       <= samp_d;
            pend_valid_q <= pend_valid_d;
            pend_bit_q   <= pend_bit_d;
            word_q       <= word_d;
            cnt_q        <= cnt_d;
            push_q       <= push_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            ovf_q        <= ovf_d;
            rd_act_q     <= rd_act_d;
            rbuf_q       <= rbuf_d;
            irq_q        <= irq_d;
        end
    end

    assign bus.data_ready = rd_act_q;
    assign bus.data_out   = rd_act_q ? rbuf_q : 32'd0;
    assign user_interrupt = irq_q;
    assign uo_out         = {irq_q, lvl4[2:0], samp_q, ovf_q, full, ~empty};
endmodule
